// File: rtl/alu_seq_nibble_tt.sv
// alu_seq_nibble_tt: sequential ALU with nibble-loaded A/B operands, registered result/flags
// and nibble-serial readout. Define ALU_MUL_EN to build the multi-cycle shift-add multiplier.
module alu_seq_nibble_tt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned NIBS  = WIDTH / 4;
    localparam int unsigned PTR_W = $clog2(NIBS);
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_LDA  = 4'd1,
        CMD_LDB  = 4'd2,
        CMD_EXEC = 4'd3,
        CMD_RDR  = 4'd4,
        CMD_CLR  = 4'd5
    } cmd_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOTA = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_PASB = 4'd11
    } op_e;

    logic [3:0] cmd;
    logic [3:0] nib;
    logic [3:0] op;

    assign cmd = io_in[7:4];
    assign nib = io_in[3:0];
    assign op  = io_in[3:0];

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             busy;
    logic             start_mul;

`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;

    // A is frozen while busy (loads are locked out), so the multiplicand is read from a_q.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    end

    assign busy      = (state_q == ST_MUL);
    assign start_mul = (op == OP_MUL);
`else
    assign busy      = 1'b0;
    assign start_mul = 1'b0;
`endif

    // Single-cycle ALU; INC/DEC reuse the adder/subtractor with operand 1.
    logic [WIDTH-1:0] arith_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        arith_b  = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b_q;
        add_full = {1'b0, a_q} + {1'b0, arith_b};
        sub_full = {1'b0, a_q} - {1'b0, arith_b};
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                alu_r = add_full[WIDTH-1:0];
                alu_c = add_full[WIDTH];
                alu_v = (a_q[MSB] == arith_b[MSB]) && (add_full[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_DEC: begin
                alu_r = sub_full[WIDTH-1:0];
                alu_c = sub_full[WIDTH];
                alu_v = (a_q[MSB] != arith_b[MSB]) && (sub_full[MSB] != a_q[MSB]);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_NOTA: alu_r = ~a_q;
            OP_SHL: begin
                alu_r = {a_q[WIDTH-2:0], 1'b0};
                alu_c = a_q[MSB];
            end
            OP_SHR: begin
                alu_r = {1'b0, a_q[WIDTH-1:1]};
                alu_c = a_q[0];
            end
            OP_PASB: alu_r = b_q;
            default: ;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        z_d   = z_q;
        c_d   = c_q;
        v_d   = v_q;
        ptr_d = ptr_q;
`ifdef ALU_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`endif
        if (cmd == CMD_CLR) begin
            a_d   = '0;
            b_d   = '0;
            r_d   = '0;
            z_d   = 1'b0;
            c_d   = 1'b0;
            v_d   = 1'b0;
            ptr_d = '0;
`ifdef ALU_MUL_EN
            state_d = ST_IDLE;
            cnt_d   = '0;
            prod_d  = '0;
`endif
        end
`ifdef ALU_MUL_EN
        else if (state_q == ST_MUL) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d = ST_IDLE;
                r_d     = prod_step[WIDTH-1:0];
                z_d     = (prod_step[WIDTH-1:0] == '0);
                c_d     = |prod_step[2*WIDTH-1:WIDTH];
                v_d     = 1'b0;
                ptr_d   = '0;
            end
        end
`endif
        else begin
            case (cmd)
                CMD_LDA: a_d = {a_q[WIDTH-5:0], nib};
                CMD_LDB: b_d = {b_q[WIDTH-5:0], nib};
                CMD_EXEC: begin
                    if (start_mul) begin
`ifdef ALU_MUL_EN
                        state_d = ST_MUL;
                        cnt_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, b_q};
`endif
                    end else begin
                        r_d   = alu_r;
                        z_d   = (alu_r == '0);
                        c_d   = alu_c;
                        v_d   = alu_v;
                        ptr_d = '0;
                    end
                end
                CMD_RDR: ptr_d = (ptr_q == PTR_W'(NIBS - 1)) ? '0 : ptr_q + PTR_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            ptr_q <= '0;
`ifdef ALU_MUL_EN
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
`endif
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            z_q   <= z_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ptr_q <= ptr_d;
`ifdef ALU_MUL_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`endif
        end
    end

    // Pointer 0 selects the most significant nibble of R.
    logic [3:0] rd_nib;

    always_comb begin
        rd_nib = '0;
        for (int unsigned i = 0; i < NIBS; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                rd_nib = r_q[WIDTH-1-4*i -: 4];
            end
        end
    end

    assign io_out = {busy, z_q, c_q, v_q, rd_nib};

endmodule

// File: tb/tb_alu_seq_nibble_tt.sv
// Self-checking bench for alu_seq_nibble_tt: directed literal scenarios plus random
// command streams compared every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_nibble_tt;

    localparam int W    = 8;
    localparam int NIBS = W / 4;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(SMAX + 1);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] io_in = 8'h00;
    logic [7:0] io_out;

    always #5 clk = ~clk;

    alu_seq_nibble_tt #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out)
    );

    // Reference model state
    longint unsigned m_a, m_b, m_r, m_pr, m_dat;
    bit              m_z, m_c, m_v, m_busy, m_pc, m_tmpv;
    int              m_left, m_ptr, m_cmd;

    int n_pass  = 0;
    int n_total = 0;

    function automatic longint sx(input longint unsigned x);
        return (((x >> (W - 1)) & 64'd1) != 0) ? longint'(x) - (longint'(1) << W) : longint'(x);
    endfunction

    function automatic bit ovf(input longint x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    function automatic void alu_ref(input int op, input longint unsigned a, input longint unsigned b,
                                    output longint unsigned r, output bit c, output bit v);
        longint unsigned bb;
        longint unsigned p;
        bb = (op == 9 || op == 10) ? 64'd1 : b;
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            0, 9: begin
                r = (a + bb) & MASK;
                c = (a + bb) > MASK;
                v = ovf(sx(a) + sx(bb));
            end
            1, 10: begin
                r = (a - bb) & MASK;
                c = a < bb;
                v = ovf(sx(a) - sx(bb));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a & MASK;
            6: begin r = (a << 1) & MASK; c = ((a >> (W - 1)) & 64'd1) != 0; end
            7: begin r = a >> 1; c = (a & 64'd1) != 0; end
            8: if (MUL_EN) begin
                p = a * b;
                r = p & MASK;
                c = (p >> W) != 0;
            end
            11: r = b;
            default: ;
        endcase
    endfunction

    function void m_clear();
        m_a = 0; m_b = 0; m_r = 0; m_pr = 0;
        m_z = 0; m_c = 0; m_v = 0; m_pc = 0;
        m_busy = 0; m_left = 0; m_ptr = 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clear();
        end else begin
            m_cmd = int'(io_in[7:4]);
            m_dat = longint'(io_in[3:0]);
            if (m_cmd == 5) begin
                m_clear();
            end else if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_r = m_pr; m_c = m_pc; m_v = 0;
                    m_z = (m_pr == 0);
                    m_ptr = 0;
                end
            end else begin
                case (m_cmd)
                    1: m_a = ((m_a << 4) | m_dat) & MASK;
                    2: m_b = ((m_b << 4) | m_dat) & MASK;
                    3: if (MUL_EN && m_dat == 8) begin
                        m_busy = 1; m_left = W;
                        alu_ref(8, m_a, m_b, m_pr, m_pc, m_tmpv);
                    end else begin
                        alu_ref(int'(m_dat), m_a, m_b, m_r, m_c, m_v);
                        m_z = (m_r == 0);
                        m_ptr = 0;
                    end
                    4: m_ptr = (m_ptr + 1) % NIBS;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [7:0] m_out();
        longint unsigned nb;
        nb = (m_r >> (W - 4 - 4 * m_ptr)) & 64'hF;
        return {m_busy, m_z, m_c, m_v, nb[3:0]};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: io_out=0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    endtask

    task automatic cmd(input int c, input int d);
        io_in = {4'(c), 4'(d)};
        @(posedge clk);
        #1;
        check("model", io_out, m_out());
    endtask

    initial begin
        int r, c, d;
        // Reset behaviour
        #2 rst = 1'b0;
        #1 check("reset_async", io_out, 8'h00);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", io_out, m_out());
        rst = 1'b1;
        cmd(0, 0);  check("nop_after_reset", io_out, 8'h00);

        // ADD 0x7F + 0x01 and readout wrap
        cmd(1, 7); cmd(1, 15); cmd(2, 0); cmd(2, 1); cmd(3, 0);
        check("add_7f_01", io_out, 8'h18);
        cmd(4, 0); check("rdr_nib1", io_out, 8'h10);
        cmd(4, 0); check("rdr_wrap", io_out, 8'h18);

        // SUB 0x05 - 0x09
        cmd(1, 0); cmd(1, 5); cmd(2, 0); cmd(2, 9); cmd(3, 1);
        check("sub_05_09", io_out, 8'h2F);
        cmd(4, 0); check("sub_rdr", io_out, 8'h2C);

        // Reserved opcode
        cmd(3, 13); check("reserved_d", io_out, 8'h40);

        // Mid-stream async reset
        cmd(1, 3); cmd(3, 11);
        #2 rst = 1'b0;
        #1 check("reset_midstream", io_out, 8'h00);
        @(negedge clk); rst = 1'b1;
        cmd(0, 0); check("nop_after_midreset", io_out, 8'h00);

`ifdef ALU_MUL_EN
        cmd(1, 0); cmd(1, 15); cmd(2, 1); cmd(2, 1); cmd(3, 8);
        for (int i = 0; i < 8; i++) begin
            check("mul_busy", io_out & 8'h80, 8'h80);
            cmd((i == 0) ? 1 : 0, 3);
        end
        check("mul_0f_11", io_out, 8'h0F);
        cmd(3, 6); check("mul_lda_ignored", io_out, 8'h01);

        cmd(1, 1); cmd(1, 0); cmd(2, 1); cmd(2, 0); cmd(3, 8);
        repeat (8) cmd(0, 0);
        check("mul_10_10", io_out, 8'h60);

        // CLR during the third busy cycle
        cmd(3, 8); cmd(0, 0); cmd(0, 0); cmd(5, 0);
        check("clr_abort", io_out, 8'h00);
        cmd(3, 0); check("clr_zeroed_ab", io_out, 8'h40);

        // Async reset during a multiply
        cmd(1, 3); cmd(2, 5); cmd(3, 8); cmd(0, 0);
        #2 rst = 1'b0;
        #1 check("reset_during_mul", io_out, 8'h00);
        @(negedge clk); rst = 1'b1;
        cmd(0, 0); check("nop_after_mul_reset", io_out, 8'h00);
`else
        cmd(1, 3); cmd(2, 5); cmd(3, 8);
        check("mul_disabled", io_out, 8'h40);
        cmd(0, 0); check("mul_disabled_no_busy", io_out, 8'h40);
`endif

        // Randomized command stream against the model
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 15);
            if (r < 22)      c = 1;
            else if (r < 44) c = 2;
            else if (r < 66) c = 3;
            else if (r < 84) c = 4;
            else if (r < 87) c = 5;
            else             c = $urandom_range(0, 15);
            cmd(c, d);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1 check("rand_reset", io_out, m_out());
                #1 rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
